// File: rtl/beam_thresh_pkg.sv
// Shared types and constants for the beam threshold loader: threshold width, number of
// threshold sets and the load sequencer state encoding.
package beam_thresh_pkg;

  localparam int THRESH_BITS = 18;
  localparam int NTHRESH     = 2;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PREFETCH = 2'd1,
    SHIFT    = 2'd2,
    COMMIT   = 2'd3
  } ldr_state_t;

endpackage

// File: rtl/beam_thresh_loader_if.sv
// Control-side bus of the beam threshold loader: table writes, load requests and the
// threshold-chain strobes heading to the beamformer slices.
interface beam_thresh_loader_if
  import beam_thresh_pkg::*;
#(
  parameter int BA_BITS = 6
);

  logic                           cfg_wr_i;
  logic                           cfg_sel_i;
  logic [BA_BITS-1:0]             cfg_beam_i;
  logic [THRESH_BITS-1:0]         cfg_dat_i;
  logic                           cfg_err_o;
  logic                           start_i;
  logic [NTHRESH-1:0]             start_mask_i;
  logic                           busy_o;
  logic                           done_o;
  logic [NTHRESH*THRESH_BITS-1:0] thresh_o;
  logic [NTHRESH-1:0]             thresh_wr_o;
  logic [NTHRESH-1:0]             thresh_update_o;

  modport master (
    output cfg_wr_i, cfg_sel_i, cfg_beam_i, cfg_dat_i, start_i, start_mask_i,
    input  cfg_err_o, busy_o, done_o, thresh_o, thresh_wr_o, thresh_update_o
  );

  modport slave (
    input  cfg_wr_i, cfg_sel_i, cfg_beam_i, cfg_dat_i, start_i, start_mask_i,
    output cfg_err_o, busy_o, done_o, thresh_o, thresh_wr_o, thresh_update_o
  );

endinterface

// File: rtl/beam_thresh_loader_thresh_table_ram.sv
// Two threshold sets of NBEAMS entries each; one synchronous write port and one registered
// read port returning both sets of the same beam in parallel. Contents survive reset.
module thresh_table_ram
  import beam_thresh_pkg::*;
#(
  parameter int                     NBEAMS         = 48,
  parameter logic [THRESH_BITS-1:0] DEFAULT_THRESH = 18'd4000,
  parameter int                     AW             = 6
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic                           we_i,
  input  logic                           wsel_i,
  input  logic [AW-1:0]                  waddr_i,
  input  logic [THRESH_BITS-1:0]         wdat_i,
  input  logic                           re_i,
  input  logic [AW-1:0]                  raddr_i,
  output logic [NTHRESH*THRESH_BITS-1:0] rdat_o
);

  logic [THRESH_BITS-1:0] mem0 [NBEAMS] = '{default: DEFAULT_THRESH};
  logic [THRESH_BITS-1:0] mem1 [NBEAMS] = '{default: DEFAULT_THRESH};

  logic [NTHRESH*THRESH_BITS-1:0] rdat_q, rdat_d;

  // Table storage writes; the address is range-checked by the caller.
  always_ff @(posedge clk_i) begin
    if (we_i && !wsel_i) begin
      mem0[waddr_i] <= wdat_i;
    end
    if (we_i && wsel_i) begin
      mem1[waddr_i] <= wdat_i;
    end
  end

  always_comb begin
    rdat_d = rdat_q;
    if (re_i) begin
      rdat_d = {mem1[raddr_i], mem0[raddr_i]};
    end else begin
      rdat_d = rdat_q;
    end
  end

  // Read register doubles as the chain data output, so it is cleared on reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rdat_q <= {(NTHRESH*THRESH_BITS){1'b0}};
    end else begin
      rdat_q <= rdat_d;
    end
  end

  assign rdat_o = rdat_q;

endmodule

// File: rtl/beam_thresh_loader.sv
// Holds the per-beam trigger threshold table and shifts it into the beamformer's cascaded
// threshold chains on request, then commits all beams in the same cycle.
module beam_thresh_loader
  import beam_thresh_pkg::*;
#(
  parameter int                     NBEAMS         = 48,
  parameter logic [THRESH_BITS-1:0] DEFAULT_THRESH = 18'd4000
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  beam_thresh_loader_if.slave  bus
);

  localparam int                 BA_BITS   = $clog2(NBEAMS);
  localparam logic [BA_BITS-1:0] LAST_ADDR = BA_BITS'(NBEAMS - 1);
  localparam logic [BA_BITS:0]   NBEAMS_W  = (BA_BITS + 1)'(NBEAMS);

  ldr_state_t          state_q, state_d;
  logic [BA_BITS-1:0]  cnt_q, cnt_d;
  logic [NTHRESH-1:0]  active_q, active_d;
  logic [NTHRESH-1:0]  pending_q, pending_d;
  logic [NTHRESH-1:0]  wr_q, wr_d;
  logic [NTHRESH-1:0]  upd_q, upd_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                err_q, err_d;

  logic [NTHRESH-1:0]  merged_s;
  logic                start_idle_s;
  logic                wr_ok_s;
  logic                wr_drop_s;
  logic                rd_en_s;
  logic [BA_BITS-1:0]  rd_addr_s;

  // Sequencer: next state, read address and registered strobe values.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    active_d     = active_q;
    rd_en_s      = 1'b0;
    rd_addr_s    = cnt_q;
    merged_s     = pending_q | (bus.start_i ? bus.start_mask_i : {NTHRESH{1'b0}});
    start_idle_s = bus.start_i && (state_q == IDLE);
    wr_ok_s      = bus.cfg_wr_i && !busy_q && ({1'b0, bus.cfg_beam_i} < NBEAMS_W);
    wr_drop_s    = bus.cfg_wr_i && !wr_ok_s;

    if (bus.start_i && (state_q != IDLE)) begin
      pending_d = merged_s;
    end else begin
      pending_d = pending_q;
    end

    case (state_q)
      IDLE: begin
        if (start_idle_s && (bus.start_mask_i != {NTHRESH{1'b0}})) begin
          active_d = bus.start_mask_i;
          state_d  = PREFETCH;
        end else begin
          state_d  = IDLE;
        end
      end
      PREFETCH: begin
        rd_en_s   = 1'b1;
        rd_addr_s = LAST_ADDR;
        cnt_d     = LAST_ADDR;
        state_d   = SHIFT;
      end
      SHIFT: begin
        // cnt_q is the beam currently on thresh_o; the read for the next beam is issued now.
        if (cnt_q == {BA_BITS{1'b0}}) begin
          state_d = COMMIT;
        end else begin
          cnt_d     = cnt_q - BA_BITS'(1);
          rd_en_s   = 1'b1;
          rd_addr_s = cnt_q - BA_BITS'(1);
        end
      end
      COMMIT: begin
        pending_d = {NTHRESH{1'b0}};
        if (merged_s != {NTHRESH{1'b0}}) begin
          active_d = merged_s;
          state_d  = PREFETCH;
        end else begin
          state_d  = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
    wr_d   = (state_d == SHIFT)  ? active_q : {NTHRESH{1'b0}};
    upd_d  = (state_d == COMMIT) ? active_q : {NTHRESH{1'b0}};
    done_d = (state_d == COMMIT) ||
             (start_idle_s && (bus.start_mask_i == {NTHRESH{1'b0}}));

    if (wr_drop_s) begin
      err_d = 1'b1;
    end else if (start_idle_s) begin
      err_d = 1'b0;
    end else begin
      err_d = err_q;
    end
  end

  // Sequencer and output registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      cnt_q     <= {BA_BITS{1'b0}};
      active_q  <= {NTHRESH{1'b0}};
      pending_q <= {NTHRESH{1'b0}};
      wr_q      <= {NTHRESH{1'b0}};
      upd_q     <= {NTHRESH{1'b0}};
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      active_q  <= active_d;
      pending_q <= pending_d;
      wr_q      <= wr_d;
      upd_q     <= upd_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  thresh_table_ram #(
    .NBEAMS         (NBEAMS),
    .DEFAULT_THRESH (DEFAULT_THRESH),
    .AW             (BA_BITS)
  ) u_table (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .we_i    (wr_ok_s),
    .wsel_i  (bus.cfg_sel_i),
    .waddr_i (bus.cfg_beam_i),
    .wdat_i  (bus.cfg_dat_i),
    .re_i    (rd_en_s),
    .raddr_i (rd_addr_s),
    .rdat_o  (bus.thresh_o)
  );

  assign bus.busy_o          = busy_q;
  assign bus.done_o          = done_q;
  assign bus.cfg_err_o       = err_q;
  assign bus.thresh_wr_o     = wr_q;
  assign bus.thresh_update_o = upd_q;

endmodule

// File: tb/tb_beam_thresh_loader.sv
// Directed bench for beam_thresh_loader: a cycle-indexed expectation model built from load
// timing rules, a threshold-chain model fed by the strobes, and literal spot checks.
module tb_beam_thresh_loader;
  import beam_thresh_pkg::*;

  localparam int NB   = 48;
  localparam int MAXC = 4096;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  beam_thresh_loader_if #(.BA_BITS(6)) bus ();

  beam_thresh_loader #(.NBEAMS(NB), .DEFAULT_THRESH(18'd4000)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  // Expected outputs per cycle number
  bit        e_busy [MAXC];
  bit        e_done [MAXC];
  bit        e_err  [MAXC];
  bit        e_zero [MAXC];
  bit  [1:0] e_wr   [MAXC];
  bit  [1:0] e_upd  [MAXC];
  bit  [1:0] e_tv   [MAXC];
  int        e_thr0 [MAXC];
  int        e_thr1 [MAXC];

  int        tbl [2][NB];
  bit        m_err = 1'b0;
  bit  [1:0] pending = 2'b00;
  int        last_commit = -1;
  int        chk_from = MAXC;

  int        sh  [2][NB];
  int        act [2][NB];

  task automatic chk(input string name, input logic [35:0] got, input logic [35:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s cycle %0d got %0d want %0d", name, cyc, got, want);
    end
  endtask

  // A load accepted in cycle c: busy c+1..c+NB+2, shifts c+2..c+NB+1, commit c+NB+2.
  task automatic schedule(input int c, input bit [1:0] m);
    for (int t = c + 1; t <= c + NB + 2; t++) e_busy[t] = 1'b1;
    for (int i = 0; i < NB; i++) begin
      e_wr[c + 2 + i] = m;
      e_tv[c + 2 + i] = m;
      e_thr0[c + 2 + i] = tbl[0][NB - 1 - i];
      e_thr1[c + 2 + i] = tbl[1][NB - 1 - i];
    end
    e_upd[c + NB + 2]  = m;
    e_done[c + NB + 2] = 1'b1;
    last_commit = c + NB + 2;
  endtask

  task automatic tick(input bit r, input bit wr, input bit sel, input logic [5:0] beam,
                      input logic [17:0] dat, input bit st, input bit [1:0] m);
    int c;
    bit busy_now;
    bit drop;
    @(posedge clk);
    #1;
    rst = r;
    bus.cfg_wr_i = wr;
    bus.cfg_sel_i = sel;
    bus.cfg_beam_i = beam;
    bus.cfg_dat_i = dat;
    bus.start_i = st;
    bus.start_mask_i = m;
    c = cyc;
    if (r) begin
      for (int t = c + 1; t <= c + 60 && t < MAXC; t++) begin
        e_busy[t] = 1'b0; e_done[t] = 1'b0; e_wr[t] = 2'b00; e_upd[t] = 2'b00; e_tv[t] = 2'b00;
      end
      e_zero[c + 1] = 1'b1;
      pending = 2'b00;
      m_err = 1'b0;
      last_commit = -1;
      if (chk_from == MAXC) chk_from = c + 1;
    end else begin
      busy_now = e_busy[c];
      drop = 1'b0;
      if (wr) begin
        if (!busy_now && beam < NB) tbl[sel][beam] = int'(dat);
        else drop = 1'b1;
      end
      if (st) begin
        if (busy_now) pending |= m;
        else begin
          m_err = 1'b0;
          if (m == 2'b00) e_done[c + 1] = 1'b1;
          else schedule(c, m);
        end
      end
      if (drop) m_err = 1'b1;
      if (c == last_commit && pending != 2'b00) begin
        schedule(c, pending);
        pending = 2'b00;
      end
    end
    e_err[c + 1] = m_err;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 1'b0, 1'b0, 6'd0, 18'd0, 1'b0, 2'b00);
  endtask

  task automatic cfg(input bit sel, input logic [5:0] beam, input logic [17:0] dat);
    tick(1'b0, 1'b1, sel, beam, dat, 1'b0, 2'b00);
  endtask

  task automatic start(input bit [1:0] m);
    tick(1'b0, 1'b0, 1'b0, 6'd0, 18'd0, 1'b1, m);
  endtask

  // Per-cycle comparison against the model, and the chain model driven by the strobes.
  always @(negedge clk) begin
    int c;
    c = cyc;
    if (c >= chk_from && c < MAXC) begin
      chk("busy", 36'(bus.busy_o), 36'(e_busy[c]));
      chk("done", 36'(bus.done_o), 36'(e_done[c]));
      chk("err", 36'(bus.cfg_err_o), 36'(e_err[c]));
      chk("wr", 36'(bus.thresh_wr_o), 36'(e_wr[c]));
      chk("update", 36'(bus.thresh_update_o), 36'(e_upd[c]));
      if (e_tv[c][0]) chk("thresh0", 36'(bus.thresh_o[17:0]), 36'(e_thr0[c]));
      if (e_tv[c][1]) chk("thresh1", 36'(bus.thresh_o[35:18]), 36'(e_thr1[c]));
      if (e_zero[c]) chk("thresh_rst", bus.thresh_o, 36'd0);
      for (int k = 0; k < 2; k++) begin
        if (bus.thresh_wr_o[k] === 1'b1) begin
          for (int b = NB - 1; b > 0; b--) sh[k][b] = sh[k][b - 1];
          sh[k][0] = int'(bus.thresh_o[18 * k +: 18]);
        end
        if (bus.thresh_update_o[k] === 1'b1) begin
          for (int b = 0; b < NB; b++) act[k][b] = sh[k][b];
        end
      end
    end
  end

  initial begin
    for (int k = 0; k < 2; k++)
      for (int b = 0; b < NB; b++) begin
        tbl[k][b] = 4000; sh[k][b] = 0; act[k][b] = 0;
      end
    bus.cfg_wr_i = 1'b0; bus.cfg_sel_i = 1'b0; bus.cfg_beam_i = 6'd0; bus.cfg_dat_i = 18'd0;
    bus.start_i = 1'b0; bus.start_mask_i = 2'b00;

    // 1: default table
    tick(1'b1, 1'b0, 1'b0, 6'd0, 18'd0, 1'b0, 2'b00);
    tick(1'b1, 1'b0, 1'b0, 6'd0, 18'd0, 1'b0, 2'b00);
    idle(1);
    @(negedge clk);
    chk("rst_busy", 36'(bus.busy_o), 36'd0);
    chk("rst_thresh", bus.thresh_o, 36'd0);
    chk("rst_err", 36'(bus.cfg_err_o), 36'd0);
    start(2'b11);
    idle(3);
    @(negedge clk);
    chk("t1_thresh", bus.thresh_o, {18'd4000, 18'd4000});
    idle(47);
    @(negedge clk);
    chk("t1_done", 36'(bus.done_o), 36'd1);
    chk("t1_update", 36'(bus.thresh_update_o), 36'd3);
    idle(2);
    chk("t1_chain", 36'(act[1][17]), 36'd4000);

    // 2: ramp table
    for (int b = 0; b < NB; b++) begin
      cfg(1'b0, 6'(b), 18'(b));
      cfg(1'b1, 6'(b), 18'(1000 + b));
    end
    start(2'b11);
    idle(2);
    @(negedge clk);
    chk("t2_first", bus.thresh_o, {18'd1047, 18'd47});
    idle(50);
    for (int b = 0; b < NB; b++) begin
      chk("t2_chain0", 36'(act[0][b]), 36'(b));
      chk("t2_chain1", 36'(act[1][b]), 36'(1000 + b));
    end

    // 3: set 0 only
    cfg(1'b0, 6'd5, 18'd777);
    cfg(1'b1, 6'd5, 18'd999);
    start(2'b01);
    idle(52);
    chk("t3_chain0_5", 36'(act[0][5]), 36'd777);
    chk("t3_chain0_4", 36'(act[0][4]), 36'd4);
    chk("t3_chain1_5", 36'(act[1][5]), 36'd1005);

    // 4: second request during a load
    start(2'b01);
    idle(9);
    start(2'b10);
    idle(40);
    @(negedge clk);
    chk("t4_done1", 36'(bus.done_o), 36'd1);
    chk("t4_upd1", 36'(bus.thresh_update_o), 36'd1);
    idle(1);
    @(negedge clk);
    chk("t4_busy_gap", 36'(bus.busy_o), 36'd1);
    idle(49);
    @(negedge clk);
    chk("t4_upd2", 36'(bus.thresh_update_o), 36'd2);
    chk("t4_done2", 36'(bus.done_o), 36'd1);
    idle(2);
    chk("t4_chain1_5", 36'(act[1][5]), 36'd999);

    // 5: dropped writes
    start(2'b11);
    idle(4);
    cfg(1'b0, 6'd3, 18'd12345);
    idle(50);
    @(negedge clk);
    chk("t5_err_busy", 36'(bus.cfg_err_o), 36'd1);
    start(2'b01);
    idle(1);
    @(negedge clk);
    chk("t5_err_clr", 36'(bus.cfg_err_o), 36'd0);
    idle(51);
    chk("t5_readback", 36'(act[0][3]), 36'd3);
    cfg(1'b0, 6'd48, 18'd54321);
    idle(1);
    @(negedge clk);
    chk("t5_err_range", 36'(bus.cfg_err_o), 36'd1);

    // 6: reset mid-load, then empty request
    start(2'b11);
    idle(19);
    tick(1'b1, 1'b0, 1'b0, 6'd0, 18'd0, 1'b0, 2'b00);
    idle(1);
    @(negedge clk);
    chk("t6_busy", 36'(bus.busy_o), 36'd0);
    chk("t6_wr", 36'(bus.thresh_wr_o), 36'd0);
    chk("t6_thresh", bus.thresh_o, 36'd0);
    chk("t6_err", 36'(bus.cfg_err_o), 36'd0);
    idle(55);
    chk("t6_chain0", 36'(act[0][5]), 36'd777);
    chk("t6_chain1", 36'(act[1][5]), 36'd999);
    start(2'b00);
    idle(1);
    @(negedge clk);
    chk("t6_done0", 36'(bus.done_o), 36'd1);
    chk("t6_nostrobe", 36'(bus.thresh_wr_o), 36'd0);
    idle(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
